reg32_piso: RTL and testbench
=============================

REG32_PISO -- requirements
Module: reg32_piso

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the word width in bits; legal range 1..64.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = serialize bit WIDTH-1 first and 0 = serialize bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning a parallel word is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a word.
REQ-007 The block SHALL have port in_data, input, WIDTH bits, the parallel word to serialize.
REQ-008 The block SHALL have port out_bit, output, 1 bit, the current serial bit.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_bit is meaningful.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the downstream accept signal.
REQ-011 The block SHALL have port out_last, output, 1 bit, meaning out_bit is the final bit of the word.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a word is being serialized.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and SHIFT, with a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 In IDLE the block SHALL drive in_ready=1 (when rst=0), out_valid=0, out_last=0, and busy=0.
REQ-015 In IDLE, on a rising edge with in_valid=1 and in_ready=1, the block SHALL capture in_data into the shift register, clear the counter, and enter SHIFT.
REQ-016 The first serial bit SHALL be valid (out_valid=1) in the cycle immediately after the accept edge, giving a load-to-first-bit latency of 1 cycle.
REQ-017 In SHIFT the block SHALL drive in_ready=0, busy=1, and out_valid=1; in_valid and in_data SHALL be ignored.
REQ-018 out_bit SHALL be shreg[WIDTH-1] when MSB_FIRST=1, and shreg[0] when MSB_FIRST=0.
REQ-019 A bit transfer SHALL occur only on an edge with out_valid=1 and out_ready=1; on that edge the shift register shifts by one toward the output end, zero-filling, and the counter increments.
REQ-020 While out_ready=0 in SHIFT, out_bit, out_last, the shift register, and the counter SHALL hold stable.
REQ-021 out_last SHALL be 1 exactly when in SHIFT with counter == WIDTH-1.
REQ-022 A transfer with out_last=1 SHALL return the FSM to IDLE on that edge; in_ready is 1 in the next cycle.
REQ-023 With out_ready held at 1, a word SHALL occupy exactly WIDTH+1 cycles from accept edge to the next possible accept edge.
REQ-024 For WIDTH=1, the first bit SHALL carry out_last=1, and a single transfer SHALL complete the word.
REQ-025 in_data changes while in_valid=0 or in_ready=0 SHALL have no effect on state.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, shift register = 0, counter = 0, out_valid=0, out_bit=0, out_last=0, busy=0, and rst SHALL take priority over any simultaneous handshake.
REQ-027 While rst=1, in_ready SHALL be 0 and no word SHALL be accepted.
REQ-028 rst asserted mid-SHIFT SHALL abort the word with no further bits emitted; after rst deasserts, the block SHALL accept a new word on the first cycle.

Verification
REQ-029 Scenario: WIDTH=32, MSB_FIRST=1, load 0xA5000001, out_ready=1 -> bits 1,0,1,0,0,1,0,1, then 23 zeros, then 1 with out_last=1; in_ready=1 on cycle 34.
REQ-030 Scenario: MSB_FIRST=0, load 0x00000003 -> first two bits 1,1, then 30 zeros, with out_last only on the 32nd bit.
REQ-031 Scenario: out_ready toggles 1,0,0,1,... during word 0xFFFF0000 -> out_bit and out_last stay constant across stall cycles, and the bit sequence is unchanged.
REQ-032 Scenario: in_valid=1 with new data throughout SHIFT -> second word accepted only in the IDLE cycle after the last transfer; first word uncorrupted.
REQ-033 Scenario: rst pulsed for 1 cycle after 10 bits of 0x12345678 -> out_valid=0 the next cycle, no remaining bits, and reload 0xDEADBEEF serializes correctly.
REQ-034 Scenario: WIDTH=1, load 1 -> one cycle with out_valid=1, out_bit=1, out_last=1, then IDLE.

Source files
------------

// File: rtl/reg32_piso.sv
// Parallel-in / serial-out converter with valid/ready handshakes on both
// sides. A word is loaded while idle and then shifted out one bit per
// downstream transfer, MSB or LSB first. The final bit is flagged with out_last.
module reg32_piso #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    // State, shift register and bit counter; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake outputs; SHIFT ignores the input side entirely.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (cnt_q == LAST_CNT);
                if (out_ready) begin
                    // Move the next bit toward the output end, zero-filling.
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The serial output is always the bit at the output end of the register.
    assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: tb/tb_reg32_piso.sv
// Bench for reg32_piso: three instances (32-bit MSB-first, 32-bit LSB-first,
// 1-bit). The reference model keeps the bits still owed for each instance as
// a queue and derives the expected handshake outputs from that queue.
module tb_reg32_piso;

    logic        clk;
    logic        rst  [3];
    logic        iv   [3];
    logic        ordy [3];
    logic [31:0] din  [3];
    logic        ir   [3];
    logic        ob   [3];
    logic        ov   [3];
    logic        ol   [3];
    logic        bz   [3];

    int n_chk;
    int n_err;

    int W  [3] = '{32, 32, 1};
    bit MS [3] = '{1'b1, 1'b0, 1'b1};

    bit mq   [3][$];   // model: bits still to be transferred
    bit logb [3][$];   // observed transferred bits
    bit logl [3][$];   // observed out_last flags of those transfers

    reg32_piso #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din[0]), .out_bit(ob[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_last(ol[0]), .busy(bz[0])
    );

    reg32_piso #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din[1]), .out_bit(ob[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_last(ol[1]), .busy(bz[1])
    );

    reg32_piso #(.WIDTH(1), .MSB_FIRST(1'b1)) u_one (
        .clk(clk), .rst(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(din[2][0:0]), .out_bit(ob[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_last(ol[2]), .busy(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each edge: reset clears, an idle offer loads the word
    // bit-by-bit in transmit order, otherwise a ready transfer pops one bit.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                mq[k].delete();
            end else if (mq[k].size() == 0) begin
                if (iv[k]) begin
                    for (int i = 0; i < W[k]; i++) begin
                        mq[k].push_back(MS[k] ? din[k][W[k]-1-i] : din[k][i]);
                    end
                end
            end else if (ordy[k]) begin
                void'(mq[k].pop_front());
            end
        end
    end

    // Compare every cycle on the falling edge and log observed transfers.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d in_ready", k),  ir[k], (!rst[k] && mq[k].size() == 0));
            chk($sformatf("u%0d out_valid", k), ov[k], (mq[k].size() != 0));
            chk($sformatf("u%0d busy", k),      bz[k], (mq[k].size() != 0));
            chk($sformatf("u%0d out_last", k),  ol[k], (mq[k].size() == 1));
            if (mq[k].size() != 0) begin
                chk($sformatf("u%0d out_bit", k), ob[k], mq[k][0]);
            end
            if (ov[k] && ordy[k] && !rst[k]) begin
                logb[k].push_back(ob[k]);
                logl[k].push_back(ol[k]);
            end
        end
    end

    function automatic logic [31:0] asm_msb(input int k, input int start, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) begin
            if (start + i < logb[k].size()) v = {v[30:0], logb[k][start+i]};
            else                             v = {v[30:0], 1'b0};
        end
        return v;
    endfunction

    function automatic logic [31:0] asm_lsb(input int k, input int start);
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) begin
            if (start + i < logb[k].size()) v[i] = logb[k][start+i];
        end
        return v;
    endfunction

    function automatic int count_last(input int k);
        int c = 0;
        for (int i = 0; i < logl[k].size(); i++) if (logl[k][i]) c++;
        return c;
    endfunction

    task automatic clr(input int k);
        logb[k].delete();
        logl[k].delete();
    endtask

    task automatic load(input int k, input logic [31:0] d);
        iv[k]  = 1'b1;
        din[k] = d;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", ir[0], 1'b0);
        chk("rst out_valid", ov[0], 1'b0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #1;
        chk("post-rst in_ready", ir[0], 1'b1);

        // MSB-first 0xA5000001 with out_ready held high.
        clr(0);
        ordy[0] = 1'b1;
        load(0, 32'hA500_0001);
        chk("a5 first bit valid", ov[0], 1'b1);
        chk("a5 first bit", ob[0], 1'b1);
        repeat (31) @(posedge clk);
        #1;
        chk("a5 last bit flag", ol[0], 1'b1);
        chk("a5 in_ready busy", ir[0], 1'b0);
        @(posedge clk);
        #1;
        chk("a5 in_ready after", ir[0], 1'b1);
        chk("a5 word", asm_msb(0, 0, 32), 32'hA500_0001);
        chk("a5 first byte", asm_msb(0, 0, 8), 32'h0000_00A5);
        chk("a5 count", logb[0].size(), 32);
        chk("a5 lasts", count_last(0), 1);
        chk("a5 last pos", logl[0][31], 1'b1);

        // LSB-first 0x00000003.
        clr(1);
        ordy[1] = 1'b1;
        load(1, 32'h0000_0003);
        repeat (33) @(posedge clk);
        #1;
        chk("lsb bit0", logb[1][0], 1'b1);
        chk("lsb bit1", logb[1][1], 1'b1);
        chk("lsb word", asm_lsb(1, 0), 32'h0000_0003);
        chk("lsb lasts", count_last(1), 1);
        chk("lsb last pos", logl[1][31], 1'b1);

        // Stalls with out_ready pattern 1,0,0,1 on 0xFFFF0000.
        clr(0);
        load(0, 32'hFFFF_0000);
        begin
            bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            int c = 0;
            ordy[0] = pat[0];
            while (bz[0] && c < 300) begin
                @(posedge clk);
                #1;
                c++;
                ordy[0] = pat[c % 4];
            end
        end
        chk("stall done", bz[0], 1'b0);
        chk("stall word", asm_msb(0, 0, 32), 32'hFFFF_0000);
        chk("stall count", logb[0].size(), 32);
        chk("stall lasts", count_last(0), 1);

        // in_valid held high with changing data throughout SHIFT.
        clr(0);
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        din[0]  = 32'h0F0F_0F0F;
        @(posedge clk);
        #1;
        din[0] = $urandom;
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk);
            #1;
            din[0] = (i == 31) ? 32'hCAFE_BABE : $urandom;
        end
        @(posedge clk);
        #1;
        chk("b2b idle ready", ir[0], 1'b1);
        chk("b2b idle valid", ov[0], 1'b0);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("b2b second accepted", ov[0], 1'b1);
        repeat (32) @(posedge clk);
        #1;
        chk("b2b word1", asm_msb(0, 0, 32), 32'h0F0F_0F0F);
        chk("b2b word2", asm_msb(0, 32, 32), 32'hCAFE_BABE);
        chk("b2b lasts", count_last(0), 2);

        // Reset mid-word after 10 bits of 0x12345678, then reload.
        clr(0);
        load(0, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        #1;
        chk("abort out_valid", ov[0], 1'b0);
        chk("abort out_last", ol[0], 1'b0);
        chk("abort in_ready", ir[0], 1'b1);
        chk("abort bits", logb[0].size(), 10);
        chk("abort prefix", asm_msb(0, 0, 10), 32'h0000_0048);
        clr(0);
        load(0, 32'hDEAD_BEEF);
        chk("reload valid", ov[0], 1'b1);
        repeat (32) @(posedge clk);
        #1;
        chk("reload word", asm_msb(0, 0, 32), 32'hDEAD_BEEF);
        chk("reload idle", bz[0], 1'b0);

        // WIDTH=1: single-bit words.
        clr(2);
        ordy[2] = 1'b1;
        load(2, 32'h1);
        chk("w1 valid", ov[2], 1'b1);
        chk("w1 bit", ob[2], 1'b1);
        chk("w1 last", ol[2], 1'b1);
        @(posedge clk);
        #1;
        chk("w1 idle valid", ov[2], 1'b0);
        chk("w1 idle ready", ir[2], 1'b1);
        load(2, 32'h0);
        chk("w1 zero bit", ob[2], 1'b0);
        @(posedge clk);
        #1;
        chk("w1 count", logb[2].size(), 2);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
